// File: rtl/man_normalizer_2.sv
// Two-lane post-add normalizer: leading-one detect, normalize, RNE round,
// exponent adjust and pack into {sign, exp, mant} mini-floats.
//
// Handshake: a beat moves across an interface on a rising edge where
// valid && ready are both high; valid never waits on ready, and data is
// held unchanged while valid && !ready. Each stage loads when it is empty
// or its current contents are leaving on the same edge.
module man_normalizer_2 #(
  parameter int expWidth   = 3,
  parameter int sigWidth   = 3,
  parameter int low_expand = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [1:0]                     in_sign,
  input  logic [2*(sigWidth+3+low_expand)-1:0] in_mag,
  input  logic [2*expWidth-1:0]          in_exp,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [2*(1+expWidth+sigWidth)-1:0] out_fp,
  output logic [1:0]                     out_ovf,
  output logic [1:0]                     out_udf
);

  localparam int MW = sigWidth + 3 + low_expand;  // magnitude width per lane
  localparam int H  = sigWidth + low_expand;      // hidden-bit position, no carry
  localparam int FW = 1 + expWidth + sigWidth;    // packed width per lane
  localparam int EW = expWidth + 2;               // signed working exponent width
  localparam int PW = $clog2(MW);                 // leading-one position width

  localparam logic signed [EW-1:0] E_MAX = EW'((1 << expWidth) - 1);
  localparam logic signed [EW-1:0] E_ONE = EW'(1);

  // Stage 1 registers
  logic                       s1_valid_q;
  logic [1:0]                 s1_sign_q, s1_sign_d;
  logic [MW-1:0]              s1_mag_q [2];
  logic [MW-1:0]              s1_mag_d [2];
  logic [PW-1:0]              s1_pos_q [2];
  logic [PW-1:0]              s1_pos_d [2];
  logic signed [EW-1:0]       s1_exp_q [2];
  logic signed [EW-1:0]       s1_exp_d [2];

  // Stage 2 registers (drive the outputs directly)
  logic                       s2_valid_q;
  logic [2*FW-1:0]            s2_fp_q, s2_fp_d;
  logic [1:0]                 s2_ovf_q, s2_ovf_d;
  logic [1:0]                 s2_udf_q, s2_udf_d;

  logic s2_load;
  logic s1_load;

  // Position of the most significant set bit; 0 for a zero magnitude,
  // which is caught separately in stage 2.
  function automatic logic [PW-1:0] lead_one(input logic [MW-1:0] m);
    lead_one = '0;
    for (int i = 0; i < MW; i++) begin
      if (m[i]) lead_one = PW'(i);
    end
  endfunction

  assign s2_load   = !s2_valid_q || out_ready;
  assign s1_load   = !s1_valid_q || s2_load;
  assign in_ready  = !rst && s1_load;
  assign out_valid = s2_valid_q;
  assign out_fp    = s2_fp_q;
  assign out_ovf   = s2_ovf_q;
  assign out_udf   = s2_udf_q;

  // Stage 1 datapath: split lanes, find leading one, unbiased exponent.
  always_comb begin
    s1_sign_d = in_sign;
    for (int l = 0; l < 2; l++) begin
      s1_mag_d[l] = in_mag[MW*l +: MW];
      s1_pos_d[l] = lead_one(s1_mag_d[l]);
      s1_exp_d[l] = EW'(in_exp[expWidth*l +: expWidth]) + EW'(s1_pos_d[l]) - EW'(H);
    end
  end

  // Stage 2 datapath: normalize by left-aligning the leading one at MW-1,
  // which covers both shift directions and keeps shifted-out bits for sticky.
  always_comb begin
    logic [MW-1:0]         norm;
    logic [sigWidth-1:0]   mant;
    logic                  guard;
    logic                  sticky;
    logic [sigWidth:0]     mant_r;
    logic [sigWidth-1:0]   mant_f;
    logic signed [EW-1:0]  exp_f;
    s2_fp_d  = '0;
    s2_ovf_d = '0;
    s2_udf_d = '0;
    for (int l = 0; l < 2; l++) begin
      norm   = s1_mag_q[l] << (PW'(MW - 1) - s1_pos_q[l]);
      mant   = norm[MW-2 -: sigWidth];
      guard  = norm[MW-2-sigWidth];
      sticky = |norm[MW-3-sigWidth:0];
      mant_r = {1'b0, mant} + (sigWidth+1)'(guard && (sticky || mant[0]));
      if (mant_r[sigWidth]) begin
        mant_f = '0;
        exp_f  = s1_exp_q[l] + E_ONE;
      end else begin
        mant_f = mant_r[sigWidth-1:0];
        exp_f  = s1_exp_q[l];
      end
      if (s1_mag_q[l] == '0) begin
        s2_fp_d[FW*l +: FW] = '0;
      end else if (exp_f > E_MAX) begin
        s2_fp_d[FW*l +: FW] = {s1_sign_q[l], {expWidth{1'b1}}, {sigWidth{1'b1}}};
        s2_ovf_d[l]         = 1'b1;
      end else if (exp_f < E_ONE) begin
        s2_fp_d[FW*l +: FW] = '0;
        s2_udf_d[l]         = 1'b1;
      end else begin
        s2_fp_d[FW*l +: FW] = {s1_sign_q[l], exp_f[expWidth-1:0], mant_f};
      end
    end
  end

  // Stage 1 register: accept a new beat whenever the stage can load.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_sign_q  <= '0;
      for (int l = 0; l < 2; l++) begin
        s1_mag_q[l] <= '0;
        s1_pos_q[l] <= '0;
        s1_exp_q[l] <= '0;
      end
    end else if (s1_load) begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        s1_sign_q <= s1_sign_d;
        for (int l = 0; l < 2; l++) begin
          s1_mag_q[l] <= s1_mag_d[l];
          s1_pos_q[l] <= s1_pos_d[l];
          s1_exp_q[l] <= s1_exp_d[l];
        end
      end
    end
  end

  // Stage 2 register: holds the packed result steady while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid_q <= 1'b0;
      s2_fp_q    <= '0;
      s2_ovf_q   <= '0;
      s2_udf_q   <= '0;
    end else if (s2_load) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s2_fp_q  <= s2_fp_d;
        s2_ovf_q <= s2_ovf_d;
        s2_udf_q <= s2_udf_d;
      end
    end
  end

endmodule

// File: tb/tb_man_normalizer_2.sv
// Bench for man_normalizer_2: table of hand-computed vectors plus
// streaming-with-stall and mid-stream reset sequences.
module tb_man_normalizer_2;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_sign;
  logic [15:0] in_mag;
  logic [5:0]  in_exp;
  logic        out_valid;
  logic        out_ready;
  logic [13:0] out_fp;
  logic [1:0]  out_ovf;
  logic [1:0]  out_udf;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1:0]  sign;
    logic [15:0] mag;
    logic [5:0]  exp;
    logic [13:0] fp;
    logic [1:0]  ovf;
    logic [1:0]  udf;
  } vec_t;

  vec_t vecs [9];
  logic [17:0] exp_q [$];

  man_normalizer_2 dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_sign  (in_sign),
    .in_mag   (in_mag),
    .in_exp   (in_exp),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_fp   (out_fp),
    .out_ovf  (out_ovf),
    .out_udf  (out_udf)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_vec(input int idx, input logic [1:0] s, input logic [15:0] m,
                         input logic [5:0] e, input logic [13:0] f,
                         input logic [1:0] o, input logic [1:0] u);
    vecs[idx].sign = s;
    vecs[idx].mag  = m;
    vecs[idx].exp  = e;
    vecs[idx].fp   = f;
    vecs[idx].ovf  = o;
    vecs[idx].udf  = u;
  endtask

  task automatic drive_vec(input int idx);
    in_sign = vecs[idx].sign;
    in_mag  = vecs[idx].mag;
    in_exp  = vecs[idx].exp;
  endtask

  // Single beat with out_ready=1: invisible after one edge, present after two.
  task automatic apply_vec(input int idx);
    drive_vec(idx);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk($sformatf("lat1_valid[%0d]", idx), 32'(out_valid), 32'd0);
    @(negedge clk);
    #1;
    chk($sformatf("valid[%0d]", idx), 32'(out_valid), 32'd1);
    chk($sformatf("fp[%0d]", idx), 32'(out_fp), 32'(vecs[idx].fp));
    chk($sformatf("ovf[%0d]", idx), 32'(out_ovf), 32'(vecs[idx].ovf));
    chk($sformatf("udf[%0d]", idx), 32'(out_udf), 32'(vecs[idx].udf));
  endtask

  initial begin
    int          sent;
    int          cyc;
    bit          prev_stall;
    bit          saw_block;
    logic [17:0] held;
    logic [17:0] front;

    // mag/exp/fp fields are {lane1, lane0}
    set_vec(0, 2'b10, {8'h00, 8'b0010_1100}, {3'd5, 3'd3}, {7'b0_000_000, 7'b0_011_011}, 2'b00, 2'b00);
    set_vec(1, 2'b10, {8'b0000_1100, 8'b0101_0000}, {3'd4, 3'd3}, {7'b1_010_100, 7'b0_100_010}, 2'b00, 2'b00);
    set_vec(2, 2'b00, {8'b0010_0010, 8'b0010_0110}, {3'd2, 3'd2}, {7'b0_010_000, 7'b0_010_010}, 2'b00, 2'b00);
    set_vec(3, 2'b10, {8'b0100_0000, 8'b0011_1110}, {3'd7, 3'd3}, {7'b1_111_111, 7'b0_100_000}, 2'b10, 2'b00);
    set_vec(4, 2'b01, {8'b0010_1100, 8'b0000_1000}, {3'd3, 3'd1}, {7'b0_011_011, 7'b0_000_000}, 2'b00, 2'b01);
    set_vec(5, 2'b00, {8'b1111_1111, 8'b0000_0001}, {3'd3, 3'd7}, {7'b0_110_000, 7'b0_010_000}, 2'b00, 2'b00);
    set_vec(6, 2'b00, {8'b0000_0100, 8'b0011_1111}, {3'd4, 3'd7}, {7'b0_001_000, 7'b0_111_111}, 2'b01, 2'b00);
    set_vec(7, 2'b00, {8'b0011_1000, 8'b0010_0000}, {3'd7, 3'd0}, {7'b0_111_110, 7'b0_000_000}, 2'b00, 2'b01);
    set_vec(8, 2'b00, {8'b1000_1100, 8'b0010_0011}, {3'd2, 3'd2}, {7'b0_100_001, 7'b0_010_001}, 2'b00, 2'b00);

    // Reset
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    in_sign = '0; in_mag = '0; in_exp = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_fp", 32'(out_fp), 32'd0);
    chk("rst_flags", 32'({out_ovf, out_udf}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);

    // Table-driven single beats
    for (int i = 0; i < 9; i++) apply_vec(i);

    // Streaming with a stall window on cycles 3..5
    @(negedge clk);
    sent = 0; cyc = 0; prev_stall = 0; saw_block = 0; held = '0;
    while ((sent < 6 || exp_q.size() > 0) && cyc < 60) begin
      out_ready = !(cyc >= 3 && cyc <= 5);
      if (sent < 6) begin
        in_valid = 1'b1;
        drive_vec(sent);
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (prev_stall) chk("stall_hold", 32'({out_fp, out_ovf, out_udf}), 32'(held));
      if (in_valid && !in_ready) saw_block = 1;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL extra_beat: got %0h expected none", {out_fp, out_ovf, out_udf});
        end else begin
          front = exp_q.pop_front();
          chk("stream_beat", 32'({out_fp, out_ovf, out_udf}), 32'(front));
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back({vecs[sent].fp, vecs[sent].ovf, vecs[sent].udf});
        sent++;
      end
      prev_stall = out_valid && !out_ready;
      held = {out_fp, out_ovf, out_udf};
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0;
    chk("stream_sent", 32'(sent), 32'd6);
    chk("stream_drained", 32'(exp_q.size()), 32'd0);
    chk("backpressure_seen", 32'(saw_block), 32'd1);
    #1;
    chk("stream_idle", 32'(out_valid), 32'd0);

    // Reset with both stages full
    @(negedge clk);
    out_ready = 1'b0;
    drive_vec(6);
    in_valid = 1'b1;
    @(negedge clk);
    drive_vec(7);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("pre_rst_valid", 32'(out_valid), 32'd1);
    chk("pre_rst_in_ready", 32'(in_ready), 32'd0);
    rst = 1'b1;
    #1;
    chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_out_fp", 32'(out_fp), 32'd0);
    chk("mid_rst_flags", 32'({out_ovf, out_udf}), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      #1;
      chk("no_stale_beat", 32'(out_valid), 32'd0);
    end
    apply_vec(8);
    @(negedge clk);
    #1;
    chk("final_idle", 32'(out_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
